// File: rtl/text_buffer_engine.sv
// text_buffer_engine
// Character / colour / highlight screen buffer of COLS x ROWS cells with a
// small command engine for bulk clear, row fill and scroll-up.
//
// Ports:
//   clock, reset                  single clock, asynchronous active-high reset
//   wr_en/wr_x/wr_y/wr_ascii/wr_colour   user character+colour cell write
//   hl_en/hl_x/hl_y/highlight     user highlight bit write
//   rd_x/rd_y -> rd_ascii/rd_colour/rd_highlight   display read, 2-cycle latency
//   cmd_valid/cmd_ready/cmd_op/cmd_row/cmd_ascii/cmd_colour   command handshake
//   busy, done, wr_drop           engine status pulses/levels
//
// Build option: define TEXT_BUFFER_SCROLL_EN to build the scroll-up (COPY)
// path. Without it, op 01 completes like the reserved op with no cell writes.
module text_buffer_engine #(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int XW       = 7,
    parameter int YW       = 6,
    parameter int ASCII_W  = 7,
    parameter int COLOUR_W = 6,
    parameter logic [ASCII_W-1:0]  NIL_CHAR   = '0,
    parameter logic [COLOUR_W-1:0] NIL_COLOUR = '1,
    parameter logic                NIL_HL     = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [XW-1:0]       wr_x,
    input  logic [YW-1:0]       wr_y,
    input  logic [ASCII_W-1:0]  wr_ascii,
    input  logic [COLOUR_W-1:0] wr_colour,
    input  logic                hl_en,
    input  logic [XW-1:0]       hl_x,
    input  logic [YW-1:0]       hl_y,
    input  logic                highlight,
    input  logic [XW-1:0]       rd_x,
    input  logic [YW-1:0]       rd_y,
    output logic [ASCII_W-1:0]  rd_ascii,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic                rd_highlight,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [YW-1:0]       cmd_row,
    input  logic [ASCII_W-1:0]  cmd_ascii,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic                busy,
    output logic                done,
    output logic                wr_drop
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] LAST_CELL = CW'(CELLS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
`ifdef TEXT_BUFFER_SCROLL_EN
    localparam logic [CW-1:0] COPY_CELLS = CW'((ROWS - 1) * COLS);
    // Copy issues COPY_CELLS reads, then spends two cycles draining the read pipe.
    localparam logic [CW-1:0] COPY_LAST  = CW'((ROWS - 1) * COLS + 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FILL  = 3'd2,
`ifdef TEXT_BUFFER_SCROLL_EN
        ST_COPY  = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_t;

    function automatic logic in_bounds(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (32'(x) < 32'(COLS)) && (32'(y) < 32'(ROWS));
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(32'(y) * 32'(COLS) + 32'(x));
    endfunction

    logic [ASCII_W-1:0]  ascii_mem  [CELLS];
    logic [COLOUR_W-1:0] colour_mem [CELLS];
    logic                hl_mem     [CELLS];

    state_t              state_r, state_nx;
    logic [CW-1:0]       cnt_r;
    logic [YW-1:0]       row_r;
    logic [ASCII_W-1:0]  fill_ascii_r;
    logic [COLOUR_W-1:0] fill_colour_r;
    logic                busy_r, ready_r, done_r;

    logic [AW-1:0]       rd_addr_r;
    logic                nil1_r, nil2_r;
    logic [ASCII_W-1:0]  q_ascii_r;
    logic [COLOUR_W-1:0] q_colour_r;
    logic                q_hl_r;

    logic                eng_we_s, eng_hl_s, steal_s;
    logic [AW-1:0]       eng_addr_s, steal_addr_s;
    logic [ASCII_W-1:0]  eng_ascii_s;
    logic [COLOUR_W-1:0] eng_colour_s;

`ifdef TEXT_BUFFER_SCROLL_EN
    logic                cp_v1_r, cp_v2_r;
    logic [AW-1:0]       cp_a1_r, cp_a2_r;
`endif

    logic accept_s, row_ok_s, wr_ok_s, hl_ok_s, rd_ok_s, usr_we_s, usr_hl_s;
    logic [AW-1:0] wr_addr_s, hl_addr_s;

    assign accept_s  = cmd_valid & ready_r;
    assign row_ok_s  = 32'(cmd_row) < 32'(ROWS);
    assign wr_ok_s   = in_bounds(wr_x, wr_y);
    assign hl_ok_s   = in_bounds(hl_x, hl_y);
    assign rd_ok_s   = in_bounds(rd_x, rd_y);
    assign wr_addr_s = wr_ok_s ? cell_addr(wr_x, wr_y) : '0;
    assign hl_addr_s = hl_ok_s ? cell_addr(hl_x, hl_y) : '0;
    assign usr_we_s  = wr_en & wr_ok_s & ~busy_r;
    assign usr_hl_s  = hl_en & hl_ok_s & ~busy_r;
    // Only in-bounds writes count as dropped; out-of-bounds ones are ignored silently.
    assign wr_drop   = busy_r & ((wr_en & wr_ok_s) | (hl_en & hl_ok_s));

    assign busy         = busy_r;
    assign cmd_ready    = ready_r;
    assign done         = done_r;
    assign rd_ascii     = nil2_r ? NIL_CHAR   : q_ascii_r;
    assign rd_colour    = nil2_r ? NIL_COLOUR : q_colour_r;
    assign rd_highlight = nil2_r ? NIL_HL     : q_hl_r;

    // State register, cell counter, latched command fields and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            row_r         <= '0;
            fill_ascii_r  <= '0;
            fill_colour_r <= '0;
            busy_r        <= 1'b0;
            ready_r       <= 1'b1;
            done_r        <= 1'b0;
        end else begin
            state_r <= state_nx;
            // Counter restarts at every state change so each phase walks from zero.
            if ((state_nx != state_r) || (state_r == ST_IDLE)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            busy_r  <= (state_nx != ST_IDLE);
            ready_r <= (state_nx == ST_IDLE);
            done_r  <= (state_r == ST_DONE);
            if (accept_s) begin
                row_r         <= cmd_row;
                fill_ascii_r  <= cmd_ascii;
                fill_colour_r <= cmd_colour;
`ifdef TEXT_BUFFER_SCROLL_EN
            end else if ((state_r == ST_COPY) && (state_nx == ST_FILL)) begin
                // Scroll finishes by blanking the freshly exposed bottom row.
                row_r <= YW'(ROWS - 1);
`endif
            end else begin
                row_r <= row_r;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        2'b00:   state_nx = ST_CLEAR;
`ifdef TEXT_BUFFER_SCROLL_EN
                        2'b01:   state_nx = ST_COPY;
`else
                        2'b01:   state_nx = ST_DONE;
`endif
                        2'b10:   state_nx = row_ok_s ? ST_FILL : ST_DONE;
                        default: state_nx = ST_DONE;
                    endcase
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CLEAR: state_nx = (cnt_r == LAST_CELL) ? ST_DONE : ST_CLEAR;
`ifdef TEXT_BUFFER_SCROLL_EN
            ST_COPY:  state_nx = (cnt_r == COPY_LAST) ? ST_FILL : ST_COPY;
`endif
            ST_FILL:  state_nx = (cnt_r == LAST_COL) ? ST_DONE : ST_FILL;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Engine outputs: cell write port and read-port steal for each state.
    always_comb begin
        eng_we_s     = 1'b0;
        eng_addr_s   = '0;
        eng_ascii_s  = fill_ascii_r;
        eng_colour_s = fill_colour_r;
        eng_hl_s     = 1'b0;
        steal_s      = 1'b0;
        steal_addr_s = '0;
        case (state_r)
            ST_CLEAR: begin
                eng_we_s   = 1'b1;
                eng_addr_s = cnt_r[AW-1:0];
            end
            ST_FILL: begin
                eng_we_s   = 1'b1;
                eng_addr_s = AW'(32'(row_r) * 32'(COLS) + 32'(cnt_r));
            end
`ifdef TEXT_BUFFER_SCROLL_EN
            ST_COPY: begin
                // Read cell a+COLS now; its data lands two cycles later and is written to a.
                steal_s = 1'b1;
                if (cnt_r < COPY_CELLS) begin
                    steal_addr_s = AW'(32'(cnt_r) + 32'(COLS));
                end else begin
                    steal_addr_s = '0;
                end
                eng_we_s     = cp_v2_r;
                eng_addr_s   = cp_a2_r;
                eng_ascii_s  = q_ascii_r;
                eng_colour_s = q_colour_r;
                eng_hl_s     = q_hl_r;
            end
`endif
            default: begin
                eng_we_s = 1'b0;
            end
        endcase
    end

`ifdef TEXT_BUFFER_SCROLL_EN
    // Copy pipeline: destination address follows the read through both read stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cp_v1_r <= 1'b0;
            cp_v2_r <= 1'b0;
            cp_a1_r <= '0;
            cp_a2_r <= '0;
        end else begin
            cp_v1_r <= (state_r == ST_COPY) && (cnt_r < COPY_CELLS);
            cp_a1_r <= cnt_r[AW-1:0];
            cp_v2_r <= cp_v1_r;
            cp_a2_r <= cp_a1_r;
        end
    end
`endif

    // Read address stage; NIL flag covers out-of-bounds reads and engine steals.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr_r <= '0;
            nil1_r    <= 1'b1;
            nil2_r    <= 1'b1;
        end else begin
            if (steal_s) begin
                rd_addr_r <= steal_addr_s;
            end else if (rd_ok_s) begin
                rd_addr_r <= cell_addr(rd_x, rd_y);
            end else begin
                rd_addr_r <= '0;
            end
            nil1_r <= steal_s | ~rd_ok_s;
            nil2_r <= nil1_r;
        end
    end

    // Cell storage: engine owns the write port while busy; read returns pre-write data.
    always_ff @(posedge clock) begin
        if (eng_we_s) begin
            ascii_mem[eng_addr_s]  <= eng_ascii_s;
            colour_mem[eng_addr_s] <= eng_colour_s;
            hl_mem[eng_addr_s]     <= eng_hl_s;
        end else begin
            if (usr_we_s) begin
                ascii_mem[wr_addr_s]  <= wr_ascii;
                colour_mem[wr_addr_s] <= wr_colour;
            end
            if (usr_hl_s) begin
                hl_mem[hl_addr_s] <= highlight;
            end
        end
        q_ascii_r  <= ascii_mem[rd_addr_r];
        q_colour_r <= colour_mem[rd_addr_r];
        q_hl_r     <= hl_mem[rd_addr_r];
    end

endmodule
